// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// Module : seg7_pkg
// Brief  : Shared constants and types for the seven-segment scan driver:
//          active-low segment patterns {g,f,e,d,c,b,a}, anode-off value,
//          digit count and the scan state encoding.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // All anodes disabled (common-anode, active-low enables)
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  // Scan states: GAP is the one-cycle dark interval between digits
  typedef enum logic [0:0] {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_t;

endpackage : seg7_pkg

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// Module : bcd_to_seg7
// Brief  : Combinational BCD to active-low seven-segment decoder.
//          Nibbles 10..15 are not valid BCD and produce a blank digit.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pattern lookup; anything outside 0..9 stays dark
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : bcd_to_seg7

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// Module : seg7_scan_driver
// Brief  : Time-multiplexes four BCD digits onto a 4-digit common-anode
//          seven-segment display. Each digit is lit for SCAN_DIV cycles,
//          followed by a one-cycle all-off gap to suppress ghosting.
//          Digit data is captured at the start of each lit period, so input
//          changes mid-digit never disturb the display.
//          Optional macro SEG7_BLINK_EN: blink the digit chosen by
//          adjust_sel while adjust_en is high (BLINK_FRAMES frames per phase).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        adjust_en,
  input  logic [1:0]  adjust_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int            PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  scan_state_t   state;
  logic [1:0]    idx;
  logic [PW-1:0] prescaler;

  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic          scan_tick;
  logic          blank_now;

  // Only one decoder: the digit under the scan index is muxed in front of it
  assign cur_digit = digits_in[{idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // Last lit cycle of the current digit
  assign scan_tick = (state == SHOW) && (prescaler == PRE_LAST);

`ifdef SEG7_BLINK_EN
  localparam int            FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  // Count whole frames (digit3 -> digit0 wrap) and flip the blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (scan_tick && (idx == 2'd3)) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blank_now = adjust_en && (idx == adjust_sel) && blink_phase;
`else
  // Adjust inputs exist for pin compatibility but have no effect here
  logic unused_adjust;
  assign unused_adjust = ^{adjust_en, adjust_sel};
  assign blank_now     = 1'b0;
`endif

  // Scan state machine with registered anode/segment/dp outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GAP;
      idx       <= 2'd0;
      prescaler <= '0;
      an        <= AN_OFF;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      case (state)
        GAP: begin
          state     <= SHOW;
          prescaler <= '0;
          if (blank_now) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
          end else begin
            an  <= ~(4'b0001 << idx);
            seg <= cur_seg;
            dp  <= ~dp_in[idx];
          end
        end
        SHOW: begin
          if (prescaler == PRE_LAST) begin
            state <= GAP;
            idx   <= idx + 2'd1;
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        default: begin
          state <= GAP;
          an    <= AN_OFF;
          seg   <= SEG_BLANK;
          dp    <= 1'b1;
        end
      endcase
    end
  end

endmodule : seg7_scan_driver

`default_nettype wire
